// File: rtl/sddr_init_sequencer.sv
// DDR3 power-up initialization sequencer: reset hold, CKE wait, tXPR, MR2/MR3/MR1/MR0, ZQCL, tZQinit.
// All outputs registered; one down-counter paces each wait (loaded with N-1, exits at 0).
// Define SDDR_INIT_SIM_SHORT_EN to shorten reset hold and CKE wait to 16 cycles each for simulation.
module sddr_init_sequencer #(
  parameter int BANK_BITS      = 3,
  parameter int ROW_BITS       = 13,
  parameter int DATA_BITS      = 16,
  parameter int RESET_CYCLES   = 60620,
  parameter int CKE_CYCLES     = 151550,
  parameter int TXPR_CYCLES    = 80,
  parameter int TMRD_CYCLES    = 4,
  parameter int TMOD_CYCLES    = 12,
  parameter int TZQINIT_CYCLES = 512,
  parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR0_VAL = 14'h0d70,
  parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR1_VAL = 14'h0044,
  parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR2_VAL = 14'h0208,
  parameter logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0] MR3_VAL = 14'h0000
) (
  input  logic                                     in_ddr_clock_i,
  input  logic                                     in_ctl_reset_n_i,
  input  logic                                     restart_i,
  output logic                                     ddr_reset_n_o,
  output logic                                     ctl_cke_o,
  output logic                                     ctl_cs_n_o,
  output logic                                     ctl_ras_n_o,
  output logic                                     ctl_cas_n_o,
  output logic                                     ctl_we_n_o,
  output logic                                     ctl_odt_o,
  output logic [ROW_BITS+$clog2(DATA_BITS/8)-1:0]  ctl_addr_o,
  output logic [BANK_BITS-1:0]                     ctl_ba_o,
  output logic                                     init_done_o,
  output logic                                     busy_o
);

  localparam int AW = ROW_BITS + $clog2(DATA_BITS/8);

`ifdef SDDR_INIT_SIM_SHORT_EN
  localparam int RST_N = 16;
  localparam int CKE_N = 16;
`else
  localparam int RST_N = RESET_CYCLES;
  localparam int CKE_N = CKE_CYCLES;
`endif

  localparam int MAX_A = (RST_N > CKE_N) ? RST_N : CKE_N;
  localparam int MAX_B = (TXPR_CYCLES > TMRD_CYCLES) ? TXPR_CYCLES : TMRD_CYCLES;
  localparam int MAX_C = (TMOD_CYCLES > TZQINIT_CYCLES) ? TMOD_CYCLES : TZQINIT_CYCLES;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_N = (MAX_C > MAX_D) ? MAX_C : MAX_D;
  localparam int CW    = $clog2(MAX_N) + 1;

  // A zero-length wait cannot be expressed by the N-1 load; ZQCL needs addr[10].
  generate
    if ((RESET_CYCLES < 1) || (CKE_CYCLES < 1) || (TXPR_CYCLES < 1) || (TMRD_CYCLES < 1) ||
        (TMOD_CYCLES < 1) || (TZQINIT_CYCLES < 1)) begin : g_bad_timing
      $error("sddr_init_sequencer: all timing parameters must be at least 1");
    end
    if (AW < 11) begin : g_bad_aw
      $error("sddr_init_sequencer: address bus must be at least 11 bits for ZQCL");
    end
  endgenerate

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [3:0] {
    S_RST_HOLD,
    S_CKE_WAIT,
    S_TXPR,
    S_MRS2,
    S_MRS3,
    S_MRS1,
    S_MRS0,
    S_ZQCL,
    S_DONE
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ZQCL  = 4'b0110;

  function automatic state_t succ(input state_t s);
    case (s)
      S_RST_HOLD: succ = S_CKE_WAIT;
      S_CKE_WAIT: succ = S_TXPR;
      S_TXPR:     succ = S_MRS2;
      S_MRS2:     succ = S_MRS3;
      S_MRS3:     succ = S_MRS1;
      S_MRS1:     succ = S_MRS0;
      S_MRS0:     succ = S_ZQCL;
      default:    succ = S_DONE;
    endcase
  endfunction

  function automatic cnt_t wait_load(input state_t s);
    case (s)
      S_RST_HOLD:             wait_load = cnt_t'(RST_N - 1);
      S_CKE_WAIT:             wait_load = cnt_t'(CKE_N - 1);
      S_TXPR:                 wait_load = cnt_t'(TXPR_CYCLES - 1);
      S_MRS2, S_MRS3, S_MRS1: wait_load = cnt_t'(TMRD_CYCLES - 1);
      S_MRS0:                 wait_load = cnt_t'(TMOD_CYCLES - 1);
      S_ZQCL:                 wait_load = cnt_t'(TZQINIT_CYCLES - 1);
      default:                wait_load = '0;
    endcase
  endfunction

  state_t          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  logic            rst_n_q, rst_n_d;
  logic            cke_q, cke_d;
  logic            odt_q, odt_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BANK_BITS-1:0] ba_q, ba_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            entry;

  // Next state: each wait state leaves when its counter reaches zero; DONE leaves only on restart.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_DONE) begin
      if (restart_i) begin
        state_d = S_RST_HOLD;
        cnt_d   = wait_load(S_RST_HOLD);
      end
    end else if (cnt_q == '0) begin
      state_d = succ(state_q);
      cnt_d   = wait_load(succ(state_q));
    end else begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  // Outputs are decoded from the next state so they land in the register with the state itself;
  // the command is issued only in the first cycle of an MRS/ZQCL state.
  always_comb begin
    entry   = (state_d != state_q);
    rst_n_d = (state_d != S_RST_HOLD);
    cke_d   = !((state_d == S_RST_HOLD) || (state_d == S_CKE_WAIT));
    odt_d   = 1'b0;
    cmd_d   = cke_d ? CMD_NOP : CMD_DESEL;
    addr_d  = '0;
    ba_d    = '0;
    if (entry) begin
      case (state_d)
        S_MRS2: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(2); addr_d = MR2_VAL; end
        S_MRS3: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(3); addr_d = MR3_VAL; end
        S_MRS1: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(1); addr_d = MR1_VAL; end
        S_MRS0: begin cmd_d = CMD_MRS; ba_d = BANK_BITS'(0); addr_d = MR0_VAL; end
        S_ZQCL: begin cmd_d = CMD_ZQCL; addr_d[10] = 1'b1; end
        default: ;
      endcase
    end
    done_d = (state_d == S_DONE);
    busy_d = !done_d;
  end

  // State, counter and output registers; reset forces the power-up values immediately.
  always_ff @(posedge in_ddr_clock_i or negedge in_ctl_reset_n_i) begin
    if (!in_ctl_reset_n_i) begin
      state_q <= S_RST_HOLD;
      cnt_q   <= wait_load(S_RST_HOLD);
      rst_n_q <= 1'b0;
      cke_q   <= 1'b0;
      odt_q   <= 1'b0;
      cmd_q   <= CMD_DESEL;
      addr_q  <= '0;
      ba_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      cke_q   <= cke_d;
      odt_q   <= odt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign ddr_reset_n_o = rst_n_q;
  assign ctl_cke_o     = cke_q;
  assign ctl_odt_o     = odt_q;
  assign {ctl_cs_n_o, ctl_ras_n_o, ctl_cas_n_o, ctl_we_n_o} = cmd_q;
  assign ctl_addr_o    = addr_q;
  assign ctl_ba_o      = ba_q;
  assign init_done_o   = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_sddr_init_sequencer.sv
// Bench for sddr_init_sequencer: scoreboard of expected sequence events (reset_n rise, cke rise,
// commands, done rise) compared against events observed on the command pins, plus per-cycle
// pin-encoding rules. Two instances: default spacing, and TMRD=1/TXPR=1.
module tb_sddr_init_sequencer;

  localparam logic [13:0] MR0 = 14'h1520;
  localparam logic [13:0] MR1 = 14'h0044;
  localparam logic [13:0] MR2 = 14'h0208;
  localparam logic [13:0] MR3 = 14'h0004;

`ifdef SDDR_INIT_SIM_SHORT_EN
  localparam int R_EFF = 16;
  localparam int C_EFF = 16;
`else
  localparam int R_EFF = 5;
  localparam int C_EFF = 7;
`endif

  typedef struct {
    int          kind;  // 0 reset_n rise, 1 cke rise, 2 MRS, 3 ZQCL, 4 done rise
    int          cyc;
    logic [2:0]  ba;
    logic [13:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic restart_m;
  logic restart_f;
  logic sel;

  logic m_rstn, m_cke, m_cs, m_ras, m_cas, m_we, m_odt, m_done, m_busy;
  logic [13:0] m_addr;
  logic [2:0]  m_ba;
  logic f_rstn, f_cke, f_cs, f_ras, f_cas, f_we, f_odt, f_done, f_busy;
  logic [13:0] f_addr;
  logic [2:0]  f_ba;

  logic        mon_rstn, mon_cke, mon_odt, mon_done, mon_busy;
  logic [3:0]  mon_cmd;
  logic [13:0] mon_addr;
  logic [2:0]  mon_ba;

  always #5 clk = ~clk;

  sddr_init_sequencer #(
    .RESET_CYCLES(5), .CKE_CYCLES(7),
    .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
  ) dut (
    .in_ddr_clock_i(clk), .in_ctl_reset_n_i(rst_n), .restart_i(restart_m),
    .ddr_reset_n_o(m_rstn), .ctl_cke_o(m_cke), .ctl_cs_n_o(m_cs), .ctl_ras_n_o(m_ras),
    .ctl_cas_n_o(m_cas), .ctl_we_n_o(m_we), .ctl_odt_o(m_odt), .ctl_addr_o(m_addr),
    .ctl_ba_o(m_ba), .init_done_o(m_done), .busy_o(m_busy)
  );

  sddr_init_sequencer #(
    .RESET_CYCLES(5), .CKE_CYCLES(7), .TXPR_CYCLES(1), .TMRD_CYCLES(1),
    .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3)
  ) dut_fast (
    .in_ddr_clock_i(clk), .in_ctl_reset_n_i(rst_n), .restart_i(restart_f),
    .ddr_reset_n_o(f_rstn), .ctl_cke_o(f_cke), .ctl_cs_n_o(f_cs), .ctl_ras_n_o(f_ras),
    .ctl_cas_n_o(f_cas), .ctl_we_n_o(f_we), .ctl_odt_o(f_odt), .ctl_addr_o(f_addr),
    .ctl_ba_o(f_ba), .init_done_o(f_done), .busy_o(f_busy)
  );

  always_comb begin
    mon_rstn = sel ? f_rstn : m_rstn;
    mon_cke  = sel ? f_cke  : m_cke;
    mon_odt  = sel ? f_odt  : m_odt;
    mon_done = sel ? f_done : m_done;
    mon_busy = sel ? f_busy : m_busy;
    mon_cmd  = sel ? {f_cs, f_ras, f_cas, f_we} : {m_cs, m_ras, m_cas, m_we};
    mon_addr = sel ? f_addr : m_addr;
    mon_ba   = sel ? f_ba   : m_ba;
  end

  // Expected events of one full sequence, cycle 0 being the first cycle of RST_HOLD.
  task automatic push_expected(input int r, input int c, input int txpr, input int tmrd,
                               input int tmod, input int tzq);
    int t;
    t = r + c + txpr;
    exp_q.push_back('{0, r, 3'd0, 14'd0});
    exp_q.push_back('{1, r + c, 3'd0, 14'd0});
    exp_q.push_back('{2, t, 3'd2, MR2});
    exp_q.push_back('{2, t + tmrd, 3'd3, MR3});
    exp_q.push_back('{2, t + 2*tmrd, 3'd1, MR1});
    exp_q.push_back('{2, t + 3*tmrd, 3'd0, MR0});
    exp_q.push_back('{3, t + 3*tmrd + tmod, 3'd0, 14'h0400});
    exp_q.push_back('{4, t + 3*tmrd + tmod + tzq, 3'd0, 14'd0});
  endtask

  // Hold reset over two edges, release at a falling edge: the following interval is cycle 0.
  task automatic do_release();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard consumer: samples one cycle per falling edge, pops an expected event for every
  // observed event, and tallies per-cycle pin-rule violations.
  task automatic scoreboard_run(input int budget, input int stop_at, input int restart_at,
                                input string tag);
    int  cyc, ncmd, viol;
    bit  p_rstn, p_cke, p_done, fin, full;
    ev_t o, x;
    cyc = 0; ncmd = 0; viol = 0;
    p_rstn = 0; p_cke = 0; p_done = 0; fin = 0; full = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      restart_m = (restart_at > 0 && cyc == restart_at);
      if (mon_odt !== 1'b0) viol++;
      if (mon_busy !== ~mon_done) viol++;
      if (p_rstn && !mon_rstn) viol++;
      if (p_cke && !mon_cke) viol++;
      if (mon_cmd == 4'b1111 || mon_cmd == 4'b0111) begin
        if (mon_addr !== 14'd0 || mon_ba !== 3'd0) viol++;
        if ((mon_cmd == 4'b1111) !== (mon_cke == 1'b0)) viol++;
      end else if (mon_cmd == 4'b0000 || mon_cmd == 4'b0110) begin
        ncmd++;
        if (mon_cke !== 1'b1) viol++;
      end else begin
        viol++;
      end
      for (int k = 0; k < 4; k++) begin
        bit hit;
        hit = 0;
        o = '{k, cyc, 3'd0, 14'd0};
        if (k == 0 && !p_rstn && mon_rstn) hit = 1;
        if (k == 1 && !p_cke && mon_cke) hit = 1;
        if (k == 2 && (mon_cmd == 4'b0000 || mon_cmd == 4'b0110)) begin
          hit = 1;
          o = '{(mon_cmd == 4'b0000) ? 2 : 3, cyc, mon_ba, mon_addr};
        end
        if (k == 3 && !p_done && mon_done) begin
          hit = 1;
          o = '{4, cyc, 3'd0, 14'd0};
          fin = 1;
          full = 1;
        end
        if (hit) begin
          n_assert++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_event: got kind=%0d cyc=%0d ba=%0d addr=%h, want none",
                     tag, o.kind, o.cyc, o.ba, o.addr);
          end else begin
            x = exp_q.pop_front();
            if (o.kind !== x.kind || o.cyc !== x.cyc || o.ba !== x.ba || o.addr !== x.addr) begin
              n_fail++;
              $display("FAIL %s event: got kind=%0d cyc=%0d ba=%0d addr=%h, want kind=%0d cyc=%0d ba=%0d addr=%h",
                       tag, o.kind, o.cyc, o.ba, o.addr, x.kind, x.cyc, x.ba, x.addr);
            end
          end
        end
      end
      p_rstn = mon_rstn; p_cke = mon_cke; p_done = mon_done;
      if (stop_at > 0 && cyc == stop_at) fin = 1;
      if (!fin && cyc >= budget) begin
        n_assert++; n_fail++;
        $display("FAIL %s timeout: got no init_done within %0d cycles, want done", tag, budget);
        fin = 1;
      end
    end
    restart_m = 1'b0;
    n_assert++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL %s pin_rules: got %0d violations, want 0", tag, viol);
    end
    if (full) begin
      n_assert++;
      if (ncmd !== 5) begin
        n_fail++;
        $display("FAIL %s cmd_count: got %0d, want 5", tag, ncmd);
      end
      n_assert++;
      if (exp_q.size() !== 0) begin
        n_fail++;
        $display("FAIL %s missing_events: got %0d left, want 0", tag, exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({m_rstn, m_cke, m_odt, m_cs, m_ras, m_cas, m_we, m_done, m_busy} !== 9'b000111101) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b, want 000111101",
               {m_rstn, m_cke, m_odt, m_cs, m_ras, m_cas, m_we, m_done, m_busy});
    end
    n_assert++;
    if (m_addr !== 14'd0 || m_ba !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got addr=%h ba=%0d, want 0/0", m_addr, m_ba);
    end
  endtask

  task automatic test_init_sequence();
    sel = 1'b0;
    do_release();
    push_expected(R_EFF, C_EFF, 80, 4, 12, 512);
    scoreboard_run(2000, 0, 0, "init");
  endtask

  task automatic test_restart_in_done();
    repeat (3) @(negedge clk);
    n_assert++;
    if (m_done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: got %b, want 1", m_done);
    end
    restart_m = 1'b1;
    @(negedge clk);
    restart_m = 1'b0;
    n_assert++;
    if ({m_done, m_busy, m_rstn, m_cke} !== 4'b0100) begin
      n_fail++;
      $display("FAIL restart_state: got done,busy,rstn,cke=%b, want 0100",
               {m_done, m_busy, m_rstn, m_cke});
    end
    push_expected(R_EFF, C_EFF, 80, 4, 12, 512);
    scoreboard_run(2000, 0, 0, "restart_done");
  endtask

  task automatic test_restart_ignored();
    do_release();
    push_expected(R_EFF, C_EFF, 80, 4, 12, 512);
    scoreboard_run(2000, 0, R_EFF + C_EFF + 10, "restart_txpr");
  endtask

  task automatic test_midseq_reset();
    do_release();
    push_expected(R_EFF, C_EFF, 80, 4, 12, 512);
    scoreboard_run(2000, R_EFF + C_EFF + 80 + 24 + 100, 0, "pre_reset");
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({m_rstn, m_cke, m_odt, m_cs, m_ras, m_cas, m_we, m_done, m_busy} !== 9'b000111101) begin
      n_fail++;
      $display("FAIL midreset_ctl: got %b, want 000111101",
               {m_rstn, m_cke, m_odt, m_cs, m_ras, m_cas, m_we, m_done, m_busy});
    end
    n_assert++;
    if (m_addr !== 14'd0 || m_ba !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_addr: got addr=%h ba=%0d, want 0/0", m_addr, m_ba);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push_expected(R_EFF, C_EFF, 80, 4, 12, 512);
    scoreboard_run(2000, 0, 0, "replay");
  endtask

  task automatic test_fast_mrs();
    sel = 1'b1;
    do_release();
    push_expected(R_EFF, C_EFF, 1, 1, 12, 512);
    scoreboard_run(2000, 0, 0, "fast");
    sel = 1'b0;
  endtask

  initial begin
    restart_m = 1'b0;
    restart_f = 1'b0;
    sel       = 1'b0;
    test_reset();
    test_init_sequence();
    test_restart_in_done();
    test_restart_ignored();
    test_midseq_reset();
    test_fast_mrs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
